// File: rtl/apb_intercon_arb.sv
// apb_intercon_arb
//   Multi-master APB interconnect. Upstream masters are arbitrated round-robin
//   and one transfer at a time is replayed on a shared downstream bus. PADDR is
//   decoded into a one-hot slave select. Unmapped addresses are answered
//   locally with PSLVERR and never reach a slave.
//
//   Optional feature macro: APB_TIMEOUT_EN
//     When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles without
//     PREADY is abandoned and answered with PSLVERR and zero read data.
//     When undefined, ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   S_PADDR    : per-master address      (MASTER_PORTS*BUS_WIDTH)
//   S_PWRITE   : per-master write strobe (MASTER_PORTS)
//   S_PSELx    : per-master select, used as the request vector
//   S_PENABLE  : per-master enable (not needed for arbitration)
//   S_PWDATA   : per-master write data   (MASTER_PORTS*BUS_WIDTH)
//   S_PRDATA   : per-master read data, non-zero only for the granted master
//   S_PREADY   : per-master ready, pulses one cycle at transfer end
//   S_PSLVERR  : per-master error (decode error or timeout)
//   M_PADDR    : shared slave address (registered)
//   M_PWRITE   : shared write strobe (registered)
//   M_PSELx    : one-hot slave select
//   M_PENABLE  : shared enable
//   M_PWDATA   : shared write data (registered)
//   M_PRDATA   : per-slave read data     (SLAVE_PORTS*BUS_WIDTH)
//   M_PREADY   : per-slave ready         (SLAVE_PORTS)

module apb_intercon_arb #(
  parameter int BUS_WIDTH       = 16,
  parameter int MASTER_PORTS    = 2,
  parameter int SLAVE_PORTS     = 4,
  parameter int SLAVE_BASE      = 'h80,
  parameter int SLAVE_SPAN_BITS = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY
);

  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam logic [BUS_WIDTH-1:0] BASE_C = SLAVE_BASE[BUS_WIDTH-1:0];
  localparam logic [BUS_WIDTH-1:0] NSLV_C = BUS_WIDTH'(SLAVE_PORTS);
  localparam logic [GW-1:0]        LAST_M = GW'(MASTER_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BUS_WIDTH-1:0] req_addr  [MASTER_PORTS];
  logic [BUS_WIDTH-1:0] req_wdata [MASTER_PORTS];
  logic [BUS_WIDTH-1:0] slv_rdata [SLAVE_PORTS];

  for (genvar i = 0; i < MASTER_PORTS; i++) begin : g_mst
    assign req_addr[i]  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
    assign req_wdata[i] = S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
  end

  for (genvar i = 0; i < SLAVE_PORTS; i++) begin : g_slv
    assign slv_rdata[i] = M_PRDATA[i*BUS_WIDTH +: BUS_WIDTH];
  end

  // PENABLE from the masters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Latched transfer context
  logic [GW-1:0]        grant;
  logic [GW-1:0]        rr_ptr;
  logic [BUS_WIDTH-1:0] addr_q;
  logic                 write_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [SW-1:0]        idx_q;
  logic                 err_q;
  logic [BUS_WIDTH-1:0] rdata_q;

  // Round-robin pick: the lowest requester at or above rr_ptr wins; if none
  // exists, wrap to the lowest requester overall. The descending loop leaves
  // the lowest matching index in each candidate.
  logic          req_any;
  logic          hi_found;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] lo_idx;
  logic [GW-1:0] pick_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = MASTER_PORTS - 1; i >= 0; i--) begin
      if (S_PSELx[i]) begin
        lo_idx = i[GW-1:0];
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = i[GW-1:0];
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  assign req_any = |S_PSELx;

  // Address decode of the picked master's address
  logic [BUS_WIDTH-1:0] pick_addr;
  logic [BUS_WIDTH-1:0] dec_full;
  logic                 dec_ok;
  logic [SW-1:0]        dec_idx;

  assign pick_addr = req_addr[pick_idx];
  assign dec_full  = (pick_addr - BASE_C) >> SLAVE_SPAN_BITS;
  assign dec_ok    = (pick_addr >= BASE_C) && (dec_full < NSLV_C);
  assign dec_idx   = dec_full[SW-1:0];

  logic slv_ready;
  logic tmo_hit;

  assign slv_ready = M_PREADY[idx_q];

`ifdef APB_TIMEOUT_EN
  // The counter holds the number of ACCESS cycles already spent waiting, so
  // the last permitted wait cycle is the one where it equals LIMIT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == ST_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ST_ACCESS) && !slv_ready) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = (state == ST_ACCESS) && !slv_ready && (tmo_cnt == TMO_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[7:0];
  assign tmo_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_any) state_nxt = dec_ok ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (slv_ready || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Transfer context; every field feeds an output that must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant   <= '0;
      rr_ptr  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            grant   <= pick_idx;
            addr_q  <= pick_addr;
            write_q <= S_PWRITE[pick_idx];
            wdata_q <= req_wdata[pick_idx];
            idx_q   <= dec_idx;
            err_q   <= !dec_ok;
            rdata_q <= '0;
          end
        end
        ST_ACCESS: begin
          if (slv_ready) begin
            rdata_q <= write_q ? '0 : slv_rdata[idx_q];
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr <= (grant == LAST_M) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    M_PSELx   = '0;
    M_PENABLE = 1'b0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    case (state)
      ST_SETUP: begin
        M_PSELx[idx_q] = 1'b1;
      end
      ST_ACCESS: begin
        M_PSELx[idx_q] = 1'b1;
        M_PENABLE      = 1'b1;
      end
      ST_RESP: begin
        S_PREADY[grant]  = 1'b1;
        S_PSLVERR[grant] = err_q;
        for (int m = 0; m < MASTER_PORTS; m++) begin
          if (int'(grant) == m) S_PRDATA[m*BUS_WIDTH +: BUS_WIDTH] = rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign M_PADDR  = addr_q;
  assign M_PWRITE = write_q;
  assign M_PWDATA = wdata_q;

endmodule

// File: tb/tb_apb_intercon_arb.sv
// tb_apb_intercon_arb
//   Directed bench for apb_intercon_arb. Responses are predicted into a
//   scoreboard queue when stimulus is issued; a monitor compares them when a
//   master sees PREADY. A bus monitor logs downstream SETUP phases and
//   PENABLE run lengths for slave-side checks.

module tb_apb_intercon_arb;

  localparam int BW = 16;
  localparam int MP = 2;
  localparam int SP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [MP*BW-1:0]  S_PADDR = '0;
  logic [MP-1:0]     S_PWRITE = '0;
  logic [MP-1:0]     S_PSELx = '0;
  logic [MP-1:0]     S_PENABLE = '0;
  logic [MP*BW-1:0]  S_PWDATA = '0;
  logic [MP*BW-1:0]  S_PRDATA;
  logic [MP-1:0]     S_PREADY;
  logic [MP-1:0]     S_PSLVERR;
  logic [BW-1:0]     M_PADDR;
  logic              M_PWRITE;
  logic [SP-1:0]     M_PSELx;
  logic              M_PENABLE;
  logic [BW-1:0]     M_PWDATA;
  logic [SP*BW-1:0]  M_PRDATA = {16'h3333, 16'hC0DE, 16'hBEEF, 16'h1111};
  logic [SP-1:0]     M_PREADY;

  apb_intercon_arb #(
    .BUS_WIDTH(BW), .MASTER_PORTS(MP), .SLAVE_PORTS(SP),
    .SLAVE_BASE('h80), .SLAVE_SPAN_BITS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave models: slave i holds PREADY low for slv_wait[i] ACCESS cycles.
  int slv_wait [SP];
  int acc_cnt  [SP];

  always_comb begin
    for (int i = 0; i < SP; i++)
      M_PREADY[i] = M_PSELx[i] && M_PENABLE && (acc_cnt[i] >= slv_wait[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < SP; i++) begin
      if (M_PSELx[i] && M_PENABLE && !M_PREADY[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      else if (!M_PENABLE) acc_cnt[i] <= 0;
    end
  end

  // Scoreboard
  typedef struct {
    int            m;
    logic [BW-1:0] rdata;
    logic          err;
    int            lat;   // -1: latency not checked
  } exp_t;

  exp_t sb_q [$];
  int   issue_cyc [MP];

  task automatic expect_resp(input int m, input logic [BW-1:0] rd, input logic err, input int lat);
    exp_t e;
    e.m = m; e.rdata = rd; e.err = err; e.lat = lat;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (S_PREADY != '0) begin
        int   gm;
        exp_t e;
        gm = 0;
        for (int i = MP - 1; i >= 0; i--) if (S_PREADY[i]) gm = i;
        check("resp_onehot", 64'($countones(S_PREADY)), 64'd1);
        if (sb_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_resp: master %0d got PREADY with nothing pending", gm);
        end else begin
          e = sb_q.pop_front();
          check("resp_master", 64'(gm), 64'(e.m));
          check("resp_rdata", 64'(S_PRDATA[gm*BW +: BW]), 64'(e.rdata));
          check("resp_slverr", 64'(S_PSLVERR[gm]), 64'(e.err));
          if (e.lat >= 0) check("resp_latency", 64'(cyc - issue_cyc[e.m]), 64'(e.lat));
          for (int i = 0; i < MP; i++)
            if (i != gm) check("idle_master_rdata", 64'(S_PRDATA[i*BW +: BW]), 64'd0);
        end
      end
    end
  end

  // Bus monitor: log SETUP phases and PENABLE run length
  logic [BW-1:0] bus_log [$];
  logic [SP-1:0] last_sel = '0;
  logic [BW-1:0] last_wdata = '0;
  logic          last_wr = 1'b0;
  int            run = 0;
  int            last_run = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (M_PSELx != '0 && !M_PENABLE) begin
        bus_log.push_back(M_PADDR);
        last_sel   = M_PSELx;
        last_wdata = M_PWDATA;
        last_wr    = M_PWRITE;
      end
      if (M_PENABLE) run = run + 1;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  // Upstream master: one APB transfer, bounded wait for PREADY
  task automatic xfer(input int m, input logic [BW-1:0] a, input logic w, input logic [BW-1:0] d);
    int n;
    S_PSELx[m]          = 1'b1;
    S_PENABLE[m]        = 1'b0;
    S_PWRITE[m]         = w;
    S_PADDR[m*BW +: BW] = a;
    S_PWDATA[m*BW +: BW] = d;
    issue_cyc[m]        = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      S_PENABLE[m] = 1'b1;
    end while (!S_PREADY[m] && n < 200);
    if (!S_PREADY[m]) check("xfer_timeout", 64'(m), 64'hFF);
    S_PSELx[m]   = 1'b0;
    S_PENABLE[m] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < SP; i++) slv_wait[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_pready", 64'(S_PREADY), 64'd0);
    check("rst_s_pslverr", 64'(S_PSLVERR), 64'd0);
    check("rst_s_prdata", 64'(S_PRDATA), 64'd0);
    check("rst_m_sel_en", 64'({M_PSELx, M_PENABLE}), 64'd0);
    check("rst_m_addr_data", 64'({M_PADDR, M_PWDATA, M_PWRITE}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait read, slave 1
    bus_log.delete();
    expect_resp(0, 16'hBEEF, 1'b0, 3);
    xfer(0, 16'h0092, 1'b0, 16'h0);
    drain();
    check("rd_setup_count", 64'(bus_log.size()), 64'd1);
    check("rd_setup_addr", 64'(bus_log[0]), 64'h92);
    check("rd_psel", 64'(last_sel), 64'b0010);
    check("rd_penable_run", 64'(last_run), 64'd1);

    // Reset asserted in the middle of ACCESS
    slv_wait[2] = 20;
    S_PSELx[1] = 1'b1;
    S_PWRITE[1] = 1'b0;
    S_PADDR[BW +: BW] = 16'h00A0;
    repeat (2) @(negedge clk);
    check("abort_in_access", 64'({M_PSELx, M_PENABLE}), 64'b01001);
    #2 reset = 1'b0;
    #1;
    check("abort_m_sel_en", 64'({M_PSELx, M_PENABLE}), 64'd0);
    check("abort_s_pready", 64'(S_PREADY), 64'd0);
    check("abort_m_addr", 64'(M_PADDR), 64'd0);
    S_PSELx[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    slv_wait[2] = 0;
    drain();

    // Contention from reset pointer: M0, M1, M0, M1
    bus_log.delete();
    expect_resp(0, 16'h0, 1'b0, -1);
    expect_resp(1, 16'h0, 1'b0, -1);
    expect_resp(0, 16'h0, 1'b0, -1);
    expect_resp(1, 16'h0, 1'b0, -1);
    fork
      begin
        xfer(0, 16'h0080, 1'b1, 16'h1234);
        xfer(0, 16'h008C, 1'b1, 16'h1357);
      end
      begin
        xfer(1, 16'h00A4, 1'b1, 16'h5678);
        xfer(1, 16'h00B2, 1'b1, 16'h2468);
      end
    join
    drain();
    check("rr_setup_count", 64'(bus_log.size()), 64'd4);
    if (bus_log.size() == 4) begin
      check("rr_order_0", 64'(bus_log[0]), 64'h80);
      check("rr_order_1", 64'(bus_log[1]), 64'hA4);
      check("rr_order_2", 64'(bus_log[2]), 64'h8C);
      check("rr_order_3", 64'(bus_log[3]), 64'hB2);
    end
    check("rr_last_wdata", 64'(last_wdata), 64'h2468);
    check("rr_last_write", 64'(last_wr), 64'd1);
    check("rr_last_sel", 64'(last_sel), 64'b1000);

    // Decode: below base, above last window, boundary addresses
    bus_log.delete();
    expect_resp(1, 16'h0, 1'b1, 1);
    xfer(1, 16'h0040, 1'b0, 16'h0);
    drain();
    expect_resp(1, 16'h0, 1'b1, 1);
    xfer(1, 16'h00C0, 1'b0, 16'h0);
    drain();
    expect_resp(1, 16'h0, 1'b1, 1);
    xfer(1, 16'h007F, 1'b0, 16'h0);
    drain();
    check("dec_err_no_psel", 64'(bus_log.size()), 64'd0);
    expect_resp(1, 16'h3333, 1'b0, 3);
    xfer(1, 16'h00BF, 1'b0, 16'h0);
    drain();
    check("dec_top_sel", 64'(last_sel), 64'b1000);

    // Slave 2 inserts 5 wait states
    slv_wait[2] = 5;
    expect_resp(0, 16'hC0DE, 1'b0, 8);
    xfer(0, 16'h00A0, 1'b0, 16'h0);
    drain();
    check("wait_penable_run", 64'(last_run), 64'd6);
    slv_wait[2] = 0;

    // Request withdrawn right after grant completes from latched values
    bus_log.delete();
    expect_resp(0, 16'h1111, 1'b0, 3);
    S_PSELx[0] = 1'b1;
    S_PWRITE[0] = 1'b0;
    S_PADDR[0 +: BW] = 16'h0088;
    issue_cyc[0] = cyc;
    @(negedge clk);
    S_PSELx[0] = 1'b0;
    S_PADDR[0 +: BW] = 16'hFFFF;
    drain();
    check("drop_setup_count", 64'(bus_log.size()), 64'd1);
    if (bus_log.size() == 1) check("drop_setup_addr", 64'(bus_log[0]), 64'h88);

`ifdef APB_TIMEOUT_EN
    // Slave 3 never ready: abandoned after 8 ACCESS cycles
    slv_wait[3] = 1000;
    expect_resp(1, 16'h0, 1'b1, 10);
    xfer(1, 16'h00B0, 1'b0, 16'h0);
    drain();
    check("tmo_penable_run", 64'(last_run), 64'd8);
    slv_wait[3] = 0;
    expect_resp(0, 16'hBEEF, 1'b0, 3);
    xfer(0, 16'h0092, 1'b0, 16'h0);
    drain();
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
